// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit; 3-cycle fetch, per-opcode execute, then back to fetch
// Ports: i_clock/i_clear (async active-high) | i_ir (opcode in [31:27]) | i_con_ff (branch condition)
//        i_stop (halt request at instruction end) | o_* datapath strobes | o_alu_op (0 ADD,1 SUB,2 AND,3 OR)
//        o_run (high outside RESET/HALT) | o_illegal (EX1 pulse on an undefined opcode)
module control_sequencer #(
  parameter int OPC_W = 5,
  parameter int ALU_W = 4
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic [31:0]      i_ir,
  input  logic             i_con_ff,
  input  logic             i_stop,
  output logic             o_PCout,
  output logic             o_PCin,
  output logic             o_IncPC,
  output logic             o_MARin,
  output logic             o_MDRin,
  output logic             o_MDRout,
  output logic             o_Read,
  output logic             o_Write,
  output logic             o_IRin,
  output logic             o_Yin,
  output logic             o_ZLowIn,
  output logic             o_ZHighIn,
  output logic             o_ZLowOut,
  output logic             o_ZHighout,
  output logic             o_HIout,
  output logic             o_LOout,
  output logic             o_Gra,
  output logic             o_Grb,
  output logic             o_Grc,
  output logic             o_Rin,
  output logic             o_Rout,
  output logic             o_BAout,
  output logic             o_RCout,
  output logic             o_CONin,
  output logic [ALU_W-1:0] o_alu_op,
  output logic             o_run,
  output logic             o_illegal
);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(5'b10011);
  localparam logic [OPC_W-1:0] OP_MFHI = OPC_W'(5'b11000);
  localparam logic [OPC_W-1:0] OP_MFLO = OPC_W'(5'b11001);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11010);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_EX1, S_EX2, S_EX3, S_EX4, S_EX5, S_HALT
  } state_t;

  state_t             r_state, w_next;
  logic [OPC_W-1:0]   r_opc;
  logic               r_con;
  logic [2:0]         w_len, w_step;
  logic               w_ld, w_ldi, w_st, w_bx, w_alu, w_imm, w_br, w_mfhi, w_mflo, w_def;
  logic               w_e1, w_e2, w_e3, w_e4, w_e5;
  logic               w_unused_ir;

  assign w_unused_ir = ^i_ir[31-OPC_W:0];

  // Opcode latches on the F2->EX1 edge (IR write-through) and is held until the next fetch
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state <= S_RESET;
      r_opc   <= '0;
      r_con   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_F2) r_opc <= i_ir[31 -: OPC_W];
      if (r_state == S_EX1) r_con <= i_con_ff;
    end
  end

  assign w_ld   = r_opc == OP_LD;
  assign w_ldi  = r_opc == OP_LDI;
  assign w_st   = r_opc == OP_ST;
  assign w_bx   = w_ld | w_ldi | w_st;
  assign w_alu  = r_opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign w_imm  = r_opc inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign w_br   = r_opc == OP_BR;
  assign w_mfhi = r_opc == OP_MFHI;
  assign w_mflo = r_opc == OP_MFLO;
  assign w_def  = w_bx | w_alu | w_imm | w_br | w_mfhi | w_mflo | (r_opc == OP_NOP) | (r_opc == OP_HALT);

  // Number of execute steps; undefined opcodes run a single empty step like nop
  assign w_len  = (w_ld | w_st) ? 3'd5 : w_br ? 3'd4 : (w_ldi | w_alu | w_imm) ? 3'd3 : 3'd1;
  assign w_step = (r_state >= S_EX1 && r_state <= S_EX5) ? 3'(r_state - S_EX1 + 4'd1) : 3'd0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1:    w_next = S_F2;
      S_F2:    w_next = S_EX1;
      S_HALT:  w_next = S_HALT;
      default: w_next = (r_state == S_EX1 && r_opc == OP_HALT) ? S_HALT :
                        (w_step == w_len) ? (i_stop ? S_HALT : S_F0) : state_t'(r_state + 4'd1);
    endcase
  end

  assign w_e1 = r_state == S_EX1;
  assign w_e2 = r_state == S_EX2;
  assign w_e3 = r_state == S_EX3;
  assign w_e4 = r_state == S_EX4;
  assign w_e5 = r_state == S_EX5;

  assign o_PCout    = (r_state == S_F0) | (w_br & w_e2);
  assign o_PCin     = w_br & w_e4 & r_con;
  assign o_IncPC    = r_state == S_F0;
  assign o_MARin    = (r_state == S_F0) | ((w_ld | w_st) & w_e3);
  assign o_MDRin    = (r_state == S_F1) | ((w_ld | w_st) & w_e4);
  assign o_MDRout   = (r_state == S_F2) | (w_ld & w_e5);
  assign o_Read     = (r_state == S_F1) | (w_ld & w_e4);
  assign o_Write    = w_st & w_e5;
  assign o_IRin     = r_state == S_F2;
  assign o_Yin      = ((w_bx | w_alu | w_imm) & w_e1) | (w_br & w_e2);
  assign o_ZLowIn   = ((w_bx | w_alu | w_imm) & w_e2) | (w_br & w_e3);
  assign o_ZHighIn  = 1'b0;
  assign o_ZLowOut  = ((w_bx | w_alu | w_imm) & w_e3) | (w_br & w_e4);
  assign o_ZHighout = 1'b0;
  assign o_HIout    = w_mfhi & w_e1;
  assign o_LOout    = w_mflo & w_e1;
  assign o_Gra      = (w_ld & w_e5) | ((w_ldi | w_alu | w_imm) & w_e3) | (w_st & w_e4) |
                      ((w_br | w_mfhi | w_mflo) & w_e1);
  assign o_Grb      = (w_bx | w_alu | w_imm) & w_e1;
  assign o_Grc      = w_alu & w_e2;
  assign o_Rin      = (w_ld & w_e5) | ((w_ldi | w_alu | w_imm) & w_e3) | ((w_mfhi | w_mflo) & w_e1);
  assign o_Rout     = ((w_alu | w_imm | w_br) & w_e1) | (w_alu & w_e2) | (w_st & w_e4);
  assign o_BAout    = w_bx & w_e1;
  assign o_RCout    = ((w_bx | w_imm) & w_e2) | (w_br & w_e3);
  assign o_CONin    = w_br & w_e1;
  assign o_alu_op   = !((w_alu | w_imm) & w_e2)             ? '0 :
                      (r_opc == OP_SUB)                     ? ALU_W'(1) :
                      (r_opc inside {OP_AND, OP_ANDI})      ? ALU_W'(2) :
                      (r_opc inside {OP_OR, OP_ORI})        ? ALU_W'(3) : '0;
  assign o_run      = !(r_state inside {S_RESET, S_HALT});
  assign o_illegal  = w_e1 & ~w_def;
endmodule
